// File: rtl/scroll_lanes_pkg.sv
// Shared definitions for the multi-lane scroller: FSM encoding, default timing
// constants and the reset stagger of lane positions.
package scroll_lanes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int unsigned DEF_INITIAL_SPEED = 250000;
    localparam int unsigned DEF_MIN_SPEED     = 25000;

    // Lanes start evenly spread over the wrap range so they do not scroll in phase.
    function automatic int unsigned stagger_pos(input int unsigned idx,
                                                input int unsigned wrap,
                                                input int unsigned lanes);
        return (idx * wrap) / lanes;
    endfunction

endpackage

// File: rtl/scroll_lane_ch.sv
// One scroll channel: period counter, modular position update and step pulse.
module scroll_lane_ch #(
    parameter int POS_W    = 11,
    parameter int WRAP     = 640,
    parameter int PER_W    = 29,
    parameter int INIT_POS = 0
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic             advance,
    input  logic             lane_en,
    input  logic             dir,
    input  logic [7:0]       move_amt,
    input  logic [PER_W-1:0] period,
    output logic [POS_W-1:0] pos,
    output logic             step
);

    localparam int EXT_W = POS_W + 1;
    localparam int AMT_W = (EXT_W > 8) ? EXT_W : 8;
    localparam logic [EXT_W-1:0] WRAP_X  = EXT_W'(WRAP);
    localparam logic [EXT_W-1:0] MAX_M   = EXT_W'(WRAP - 1);
    localparam logic [AMT_W-1:0] MAX_M_A = AMT_W'(WRAP - 1);

    logic [PER_W-1:0] count;
    logic [AMT_W-1:0] amt_w;
    logic [EXT_W-1:0] m, pos_x, fwd_sum, next_x;
    logic             due;

    // All wrap arithmetic stays within POS_W+1 bits: pos and m are both below WRAP.
    always_comb begin
        amt_w   = AMT_W'(move_amt);
        m       = (amt_w > MAX_M_A) ? MAX_M : EXT_W'(amt_w);
        pos_x   = {1'b0, pos};
        fwd_sum = pos_x + m;
        if (dir) begin
            next_x = (fwd_sum >= WRAP_X) ? fwd_sum - WRAP_X : fwd_sum;
        end else begin
            next_x = (pos_x < m) ? pos_x + WRAP_X - m : pos_x - m;
        end
    end

    // count+1 >= period is count >= period-1 without underflow; >= also catches a shrunk period.
    assign due = ({1'b0, count} + {{PER_W{1'b0}}, 1'b1}) >= {1'b0, period};

    always_ff @(posedge clk) begin
        if (!sys_rst || clear) begin
            count <= '0;
            pos   <= POS_W'(INIT_POS);
            step  <= 1'b0;
        end else if (!lane_en) begin
            count <= '0;
            step  <= 1'b0;
        end else if (advance && due) begin
            count <= '0;
            pos   <= next_x[POS_W-1:0];
            step  <= 1'b1;
        end else begin
            if (advance) begin
                count <= count + PER_W'(1);
            end
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/scroll_lanes.sv
// Multi-lane scroller top: run/halt FSM, shared speed register with level-up
// ramp, and one scroll_lane_ch per lane with a per-lane period skew.
module scroll_lanes
    import scroll_lanes_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int POS_W         = 11,
    parameter int WRAP          = 640,
    parameter int SPD_W         = 24,
    parameter int INITIAL_SPEED = DEF_INITIAL_SPEED,
    parameter int MIN_SPEED     = DEF_MIN_SPEED,
    parameter int LANE_SKEW     = 1000
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       game_rst,
    input  logic                       start,
    input  logic                       halt,
    input  logic                       level_up,
    input  logic [SPD_W-1:0]           speed_change,
    input  logic [7:0]                 move_amt,
    input  logic [NUM_LANES-1:0]       dir,
    input  logic [NUM_LANES-1:0]       lane_en,
    output logic [NUM_LANES*POS_W-1:0] pos,
    output logic [SPD_W-1:0]           speed,
    output logic [NUM_LANES-1:0]       step,
    output logic                       running
);

    localparam int PER_W = SPD_W + 5;

    state_t           state, state_next;
    logic             lanes_go, level_ok;
    logic [SPD_W:0]   floor_sum;
    logic [SPD_W-1:0] speed_dec;

    always_ff @(posedge clk) begin
        if (!sys_rst || game_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (halt)  state_next = ST_HALT;
            ST_HALT: if (!halt) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // Halt wins over any step due on the edge that leaves RUN.
    always_comb begin
        lanes_go = (state == ST_RUN) && !halt;
        level_ok = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst || game_rst) begin
            running <= 1'b0;
        end else begin
            running <= (state_next == ST_RUN);
        end
    end

    // One extra bit keeps speed_change + MIN_SPEED from wrapping.
    always_comb begin
        floor_sum = {1'b0, speed_change} + (SPD_W+1)'(MIN_SPEED);
        speed_dec = ({1'b0, speed} > floor_sum) ? speed - speed_change : SPD_W'(MIN_SPEED);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst || game_rst) begin
            speed <= SPD_W'(INITIAL_SPEED);
        end else if (level_up && level_ok) begin
            speed <= speed_dec;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [PER_W-1:0] period;
        assign period = PER_W'(speed) + PER_W'(i * LANE_SKEW);

        scroll_lane_ch #(
            .POS_W   (POS_W),
            .WRAP    (WRAP),
            .PER_W   (PER_W),
            .INIT_POS(stagger_pos(i, WRAP, NUM_LANES))
        ) u_lane (
            .clk     (clk),
            .sys_rst (sys_rst),
            .clear   (game_rst),
            .advance (lanes_go),
            .lane_en (lane_en[i]),
            .dir     (dir[i]),
            .move_amt(move_amt),
            .period  (period),
            .pos     (pos[i*POS_W +: POS_W]),
            .step    (step[i])
        );
    end

endmodule

// File: tb/tb_scroll_lanes.sv
// Randomized bench for scroll_lanes against an edge-level behavioural model of
// lane timing, modular positions and the speed ramp.
module tb_scroll_lanes;

    localparam int NL       = 4;
    localparam int PW       = 8;
    localparam int WR       = 200;
    localparam int SW       = 24;
    localparam int INIT_SPD = 20;
    localparam int MIN_SPD  = 10;
    localparam int SKEW     = 2;

    logic           clk = 1'b0;
    logic           sys_rst, game_rst, start, halt, level_up;
    logic [SW-1:0]  speed_change;
    logic [7:0]     move_amt;
    logic [NL-1:0]  dir, lane_en;
    logic [NL*PW-1:0] pos;
    logic [SW-1:0]  speed;
    logic [NL-1:0]  step;
    logic           running;

    int n_tests = 0;
    int n_fail  = 0;

    int     m_pos[NL];
    int     m_elapsed[NL];
    bit     m_step[NL];
    longint m_speed;
    bit     m_started, m_run, m_running;
    logic [PW-1:0] exp_q[$];

    scroll_lanes #(
        .NUM_LANES(NL), .POS_W(PW), .WRAP(WR), .SPD_W(SW),
        .INITIAL_SPEED(INIT_SPD), .MIN_SPEED(MIN_SPD), .LANE_SKEW(SKEW)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .game_rst(game_rst), .start(start),
        .halt(halt), .level_up(level_up), .speed_change(speed_change),
        .move_amt(move_amt), .dir(dir), .lane_en(lane_en), .pos(pos),
        .speed(speed), .step(step), .running(running)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_pos[i]     = (i * WR) / NL;
            m_elapsed[i] = 0;
            m_step[i]    = 1'b0;
        end
        m_speed   = INIT_SPD;
        m_started = 1'b0;
        m_run     = 1'b0;
        m_running = 1'b0;
        exp_q.delete();
    endtask

    // Lane i steps once period_i edges of unhalted RUN have elapsed since its last step/clear.
    task automatic model_edge();
        int amt;
        if (!sys_rst || game_rst) begin
            model_reset();
        end else begin
            amt = (int'(move_amt) > WR - 1) ? WR - 1 : int'(move_amt);
            for (int i = 0; i < NL; i++) begin
                m_step[i] = 1'b0;
                if (!lane_en[i]) begin
                    m_elapsed[i] = 0;
                end else if (m_run && !halt) begin
                    m_elapsed[i]++;
                    if (longint'(m_elapsed[i]) >= m_speed + i * SKEW) begin
                        m_elapsed[i] = 0;
                        m_pos[i] = dir[i] ? (m_pos[i] + amt) % WR : (m_pos[i] - amt + WR) % WR;
                        m_step[i] = 1'b1;
                        if (i == 0) exp_q.push_back(PW'(m_pos[0]));
                    end
                end
            end
            if (level_up && m_started) begin
                if (m_speed > longint'(speed_change) + MIN_SPD) m_speed = m_speed - longint'(speed_change);
                else m_speed = MIN_SPD;
            end
            if (m_started) begin
                m_run = !halt;
            end else if (start) begin
                m_started = 1'b1;
                m_run     = 1'b1;
            end
            m_running = m_run;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NL; i++) begin
            check($sformatf("pos%0d", i), pos[i*PW +: PW], m_pos[i]);
            check($sformatf("step%0d", i), step[i], m_step[i]);
        end
        check("speed", speed, m_speed);
        check("running", running, m_running);
        if (step[0]) begin
            if (exp_q.size() == 0) check("sb_extra_step", 1, 0);
            else check("sb_lane0_pos", pos[PW-1:0], exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive_random();
        if ($urandom_range(0, 15) == 0) halt = ~halt;
        level_up     = ($urandom_range(0, 19) == 0);
        speed_change = ($urandom_range(0, 9) == 0) ? 24'hFFFFFF : SW'($urandom_range(0, 6));
        move_amt     = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) dir = NL'($urandom);
        if ($urandom_range(0, 11) == 0) lane_en = NL'($urandom) | NL'($urandom);
        start    = ($urandom_range(0, 7) == 0);
        game_rst = ($urandom_range(0, 299) == 0);
        sys_rst  = ($urandom_range(0, 999) != 0);
    endtask

    initial begin
        int exp_spd[3];
        exp_spd[0] = 16; exp_spd[1] = 12; exp_spd[2] = 10;

        sys_rst = 1'b0; game_rst = 1'b0; start = 1'b0; halt = 1'b0; level_up = 1'b0;
        speed_change = '0; move_amt = 8'd5; dir = '1; lane_en = '1;
        model_reset();
        repeat (2) tick();
        check("rst_pos0", pos[0*PW +: PW], 0);
        check("rst_pos1", pos[1*PW +: PW], 50);
        check("rst_pos2", pos[2*PW +: PW], 100);
        check("rst_pos3", pos[3*PW +: PW], 150);
        check("rst_speed", speed, INIT_SPD);
        check("rst_running", running, 0);
        check("rst_step", step, 0);
        sys_rst = 1'b1;

        // first steps: lane0 after 20 edges, lane1 after 22
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("t_lane0_quiet", step[0], 0);
        tick();
        check("t_lane0_first", step[0], 1);
        check("t_lane0_pos", pos[0*PW +: PW], 5);
        repeat (2) tick();
        check("t_lane1_first", step[1], 1);
        check("t_lane1_pos", pos[1*PW +: PW], 55);
        repeat (40) tick();

        halt = 1'b1;
        repeat (20) tick();
        halt = 1'b0;
        repeat (30) tick();

        // speed ramp to the floor from a fresh game
        game_rst = 1'b1;
        tick();
        game_rst = 1'b0;
        check("grst_speed", speed, INIT_SPD);
        check("grst_pos3", pos[3*PW +: PW], 150);
        check("grst_running", running, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        speed_change = 24'd4;
        for (int k = 0; k < 3; k++) begin
            level_up = 1'b1;
            tick();
            level_up = 1'b0;
            check($sformatf("ramp%0d", k), speed, exp_spd[k]);
            repeat (3) tick();
        end

        lane_en = 4'b1011;
        dir     = 4'b0101;
        move_amt = 8'd255;
        repeat (60) tick();
        lane_en = '1;
        repeat (20) tick();

        repeat (3000) begin
            drive_random();
            tick();
        end

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
